// File: rtl/secuenciador_resta.sv
// rtl/secuenciador_resta.sv - bit-serial subtractor, LSB first, one full-subtractor cell reused per bit
module secuenciador_resta #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] r,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] res;
  logic             borrow;
  logic [CW-1:0]    cnt;
  logic             diff_bit;
  logic             borrow_nx;

  always_comb begin
    diff_bit  = sa[0] ^ sb[0] ^ borrow;
    borrow_nx = (~sa[0] & sb[0]) | (~sa[0] & borrow) | (sb[0] & borrow);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt == LAST) state_nx = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // r/cout only change on the final bit so partial differences never show
  always_ff @(posedge clk) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      res    <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      r      <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            borrow <= cin;
            cnt    <= '0;
          end
        end
        RUN: begin
          res    <= {diff_bit, res[WIDTH-1:1]};
          borrow <= borrow_nx;
          sa     <= sa >> 1;
          sb     <= sb >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) begin
            r    <= {diff_bit, res[WIDTH-1:1]};
            cout <= borrow_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
